// File: rtl/sc_mul_pkg.sv
// Shared types and constants for the stochastic-computing multiply/accumulate block.
package sc_mul_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } sc_state_e;

   localparam logic MODE_UNI = 1'b0;
   localparam logic MODE_BI  = 1'b1;

endpackage

// File: rtl/sc_mul_lane.sv
// One stochastic multiplier lane: operand buffers, comparators, AND/XNOR and ones counter.
module sc_mul_lane
   import sc_mul_pkg::*;
#(
   parameter int DATAWD = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              run,
   input  logic              last,
   input  logic              mode,
   input  logic [DATAWD-1:0] a_in,
   input  logic [DATAWD-1:0] b_in,
   input  logic [DATAWD-1:0] seq_a,
   input  logic [DATAWD-1:0] seq_b,
   output logic              c,
   output logic [DATAWD:0]   cnt
);

   logic [DATAWD-1:0] a_buf;
   logic [DATAWD-1:0] b_buf;
   logic [DATAWD:0]   acc;
   logic [DATAWD:0]   acc_next;
   logic              a_bit;
   logic              b_bit;
   logic              prod;

   always_comb begin
      a_bit    = (a_buf > seq_a);
      b_bit    = (b_buf > seq_b);
      prod     = (mode == MODE_BI) ? ~(a_bit ^ b_bit) : (a_bit & b_bit);
      c        = run & prod;
      acc_next = acc + {{DATAWD{1'b0}}, c};
   end

   // The final bit of the run is folded straight into the published count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_buf <= '0;
         b_buf <= '0;
         acc   <= '0;
         cnt   <= '0;
      end else begin
         if (load) begin
            a_buf <= a_in;
            b_buf <= b_in;
            acc   <= '0;
         end else if (run) begin
            acc <= acc_next;
         end
         if (last) begin
            cnt <= acc_next;
         end
      end
   end

endmodule

// File: rtl/sc_mul_acc.sv
// Multi-lane stochastic multiplier with a shared run FSM and cycle counter.
// start/abort are level requests sampled each clock; start is taken only in IDLE and abort wins over start.
module sc_mul_acc
   import sc_mul_pkg::*;
#(
   parameter int DATAWD = 8,
   parameter int LANES  = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       abort,
   input  logic                       mode,
   input  logic [LANES*DATAWD-1:0]    iA,
   input  logic [LANES*DATAWD-1:0]    iB,
   input  logic [DATAWD-1:0]          sobolSeqA,
   input  logic [DATAWD-1:0]          sobolSeqB,
   output logic                       busy,
   output logic [LANES-1:0]           oC,
   output logic                       done,
   output logic [LANES*(DATAWD+1)-1:0] oCnt,
   output logic [1:0]                 state_dbg
);

   localparam logic [DATAWD-1:0] CNT_LAST = '1;

   sc_state_e         state;
   sc_state_e         state_next;
   logic [DATAWD-1:0] cyc_cnt;
   logic              mode_buf;
   logic              load;
   logic              run;
   logic              last;

   assign load      = (state == ST_IDLE) && start && !abort;
   assign run       = (state == ST_RUN);
   assign last      = run && !abort && (cyc_cnt == CNT_LAST);
   assign state_dbg = state;

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (load) state_next = ST_RUN;
         end
         ST_RUN: begin
            busy = 1'b1;
            if (abort) state_next = ST_IDLE;
            else if (cyc_cnt == CNT_LAST) state_next = ST_DONE;
         end
         ST_DONE: begin
            done       = !abort;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         cyc_cnt  <= '0;
         mode_buf <= MODE_UNI;
      end else begin
         state <= state_next;
         if (load) begin
            cyc_cnt  <= '0;
            mode_buf <= mode;
         end else if (run) begin
            cyc_cnt <= cyc_cnt + 1'b1;
         end
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      sc_mul_lane #(.DATAWD(DATAWD)) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .load  (load),
         .run   (run),
         .last  (last),
         .mode  (mode_buf),
         .a_in  (iA[k*DATAWD +: DATAWD]),
         .b_in  (iB[k*DATAWD +: DATAWD]),
         .seq_a (sobolSeqA),
         .seq_b (sobolSeqB),
         .c     (oC[k]),
         .cnt   (oCnt[k*(DATAWD+1) +: DATAWD+1])
      );
   end

endmodule

// File: tb/tb_sc_mul_acc.sv
// Self-checking bench for sc_mul_acc: run-level behavioural model, per-cycle compare, directed and random runs.
module tb_sc_mul_acc;

   localparam int DW     = 8;
   localparam int LN     = 4;
   localparam int CW     = DW + 1;
   localparam int RUNLEN = 1 << DW;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic              mode = 1'b0;
   logic [LN*DW-1:0]  iA = '0;
   logic [LN*DW-1:0]  iB = '0;
   logic [DW-1:0]     sobolSeqA = '0;
   logic [DW-1:0]     sobolSeqB = '0;
   logic              busy;
   logic              done;
   logic [LN-1:0]     oC;
   logic [LN*CW-1:0]  oCnt;
   logic [1:0]        state_dbg;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   bit chk_en = 1'b0;
   bit seq_rand = 1'b0;
   logic [LN*CW-1:0] exp_q[$];

   // Run-level model: operands of the accepted run, running ones totals, last published counts.
   bit m_run = 1'b0;
   bit m_fin = 1'b0;
   int m_idx = 0;
   bit m_mode = 1'b0;
   int m_opa[LN];
   int m_opb[LN];
   int m_ones[LN];
   int m_cnt[LN];

   sc_mul_acc #(.DATAWD(DW), .LANES(LN)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .mode      (mode),
      .iA        (iA),
      .iB        (iB),
      .sobolSeqA (sobolSeqA),
      .sobolSeqB (sobolSeqB),
      .busy      (busy),
      .oC        (oC),
      .done      (done),
      .oCnt      (oCnt),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   function automatic bit exp_bit(int k, logic [DW-1:0] sa, logic [DW-1:0] sb);
      bit a;
      bit b;
      a = m_opa[k] > int'(sa);
      b = m_opb[k] > int'(sb);
      return m_mode ? (a == b) : (a && b);
   endfunction

   function automatic logic [LN*CW-1:0] pack_cnt();
      logic [LN*CW-1:0] r;
      r = '0;
      for (int k = 0; k < LN; k++) r[k*CW +: CW] = CW'(m_cnt[k]);
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_run = 1'b0;
         m_fin = 1'b0;
         m_idx = 0;
         m_mode = 1'b0;
         for (int k = 0; k < LN; k++) begin
            m_opa[k] = 0; m_opb[k] = 0; m_ones[k] = 0; m_cnt[k] = 0;
         end
      end else if (m_fin) begin
         m_fin = 1'b0;
      end else if (m_run) begin
         if (abort) begin
            m_run = 1'b0;
         end else begin
            for (int k = 0; k < LN; k++) m_ones[k] += int'(exp_bit(k, sobolSeqA, sobolSeqB));
            if (m_idx == RUNLEN - 1) begin
               m_cnt = m_ones;
               m_run = 1'b0;
               m_fin = 1'b1;
               exp_q.push_back(pack_cnt());
            end else begin
               m_idx++;
            end
         end
      end else if (start && !abort) begin
         for (int k = 0; k < LN; k++) begin
            m_opa[k]  = int'(iA[k*DW +: DW]);
            m_opb[k]  = int'(iB[k*DW +: DW]);
            m_ones[k] = 0;
         end
         m_mode = mode;
         m_idx  = 0;
         m_run  = 1'b1;
      end
   end

   // Sequences follow the run's cycle index unless random sequences are selected.
   always @(posedge clk) begin
      #1;
      sobolSeqA = (m_run && !seq_rand) ? DW'(m_idx) : DW'($urandom);
      sobolSeqB = (m_run && !seq_rand) ? DW'(m_idx) : DW'($urandom);
   end

   always @(negedge clk) begin
      logic [LN-1:0] eo;
      if (chk_en) begin
         eo = '0;
         if (m_run) for (int k = 0; k < LN; k++) eo[k] = exp_bit(k, sobolSeqA, sobolSeqB);
         chk("busy", busy, m_run);
         chk("done", done, m_fin && !abort);
         chk("oC", oC, eo);
         chk("oCnt", oCnt, pack_cnt());
         if (done) begin
            if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
            else chk("sb_oCnt", oCnt, exp_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lane(int k, int a, int b);
      iA[k*DW +: DW] = DW'(a);
      iB[k*DW +: DW] = DW'(b);
   endtask

   task automatic kick(bit md);
      mode  = md;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < RUNLEN + 20) begin
         step();
         n++;
      end
      if (!done) chk("done_timeout", done, 1);
   endtask

   function automatic logic [CW-1:0] lane_cnt(int k);
      return oCnt[k*CW +: CW];
   endfunction

   initial begin
      int n;
      logic [LN*CW-1:0] bip_pack;
      bip_pack = {9'd156, 9'd256, 9'd256, 9'd192};

      #2 rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      chk_en = 1'b1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_oC", oC, 0);
      chk("rst_oCnt", oCnt, 0);
      step();

      abort = 1'b1; start = 1'b1;
      step();
      abort = 1'b0; start = 1'b0;
      chk("idle_abort_prio", busy, 0);

      // Unipolar directed run
      set_lane(0, 128, 64); set_lane(1, 255, 255); set_lane(2, 0, 200); set_lane(3, 37, 99);
      kick(1'b0);
      wait_done(n);
      chk("uni_latency", n, RUNLEN);
      chk("uni_l0", lane_cnt(0), 64);
      chk("uni_l1", lane_cnt(1), 255);
      chk("uni_l2", lane_cnt(2), 0);
      chk("uni_l3", lane_cnt(3), 37);
      step();
      chk("done_single", done, 0);

      // Bipolar directed run, including the full-scale count of 256
      set_lane(0, 128, 64); set_lane(1, 0, 0); set_lane(2, 255, 255); set_lane(3, 200, 100);
      kick(1'b1);
      wait_done(n);
      chk("bi_latency", n, RUNLEN);
      chk("bi_pack", oCnt, bip_pack);
      step();

      // Abort at RUN cycle 100
      iA = $urandom; iB = $urandom;
      kick(1'b0);
      repeat (100) step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_keep", oCnt, bip_pack);
      step();

      // start held through the run, operands changed mid-run
      set_lane(0, 128, 64); set_lane(1, 10, 20); set_lane(2, 255, 0); set_lane(3, 64, 128);
      mode = 1'b0; start = 1'b1;
      step();
      repeat (50) step();
      iA = $urandom;
      wait_done(n);
      chk("held_latency", 50 + n, RUNLEN);
      chk("held_l0", lane_cnt(0), 64);
      chk("held_l1", lane_cnt(1), 10);
      chk("held_l2", lane_cnt(2), 0);
      chk("held_l3", lane_cnt(3), 64);
      step();
      chk("held_gap", busy, 0);
      step();
      chk("held_rerun", busy, 1);
      start = 1'b0; abort = 1'b1;
      step();
      abort = 1'b0;
      step();

      // Reset at RUN cycle 50, then a clean run
      set_lane(0, 128, 64); set_lane(1, 255, 255); set_lane(2, 0, 200); set_lane(3, 37, 99);
      kick(1'b0);
      repeat (50) step();
      rst_n = 1'b0;
      #1;
      chk("mrst_busy", busy, 0);
      chk("mrst_done", done, 0);
      chk("mrst_oC", oC, 0);
      chk("mrst_oCnt", oCnt, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      kick(1'b0);
      wait_done(n);
      chk("post_rst_latency", n, RUNLEN);
      chk("post_rst_l0", lane_cnt(0), 64);
      chk("post_rst_l1", lane_cnt(1), 255);
      step();

      // Random runs
      repeat (8) begin
         iA = $urandom; iB = $urandom;
         seq_rand = 1'($urandom_range(0, 1));
         kick(1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 250)) step();
            abort = 1'b1;
            step();
            abort = 1'b0;
         end else begin
            repeat ($urandom_range(1, 200)) step();
            iA = $urandom;
            wait_done(n);
         end
         repeat ($urandom_range(1, 3)) step();
      end
      seq_rand = 1'b0;

      repeat (3) step();
      chk("sb_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sc_mul_acc.md
SC_MUL_ACC -- requirements
Module: sc_mul_acc

Interface
REQ-001 Parameter DATAWD, default 8: operand, Sobol-sequence and cycle-counter width; stream length is 2^DATAWD cycles.
REQ-002 Parameter LANES, default 4: number of independent multiplier lanes.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request a new stream run; accepted only in IDLE.
REQ-006 abort  input  1  terminate the current run and return to IDLE.
REQ-007 mode  input  1  0 = unipolar (AND), 1 = bipolar (XNOR); latched on start.
REQ-008 iA  input  LANES*DATAWD  operand A per lane; lane k occupies bits [k*DATAWD +: DATAWD].
REQ-009 iB  input  LANES*DATAWD  operand B per lane, same packing as iA.
REQ-010 sobolSeqA  input  DATAWD  shared random sequence for A comparisons.
REQ-011 sobolSeqB  input  DATAWD  shared random sequence for B comparisons.
REQ-012 busy  output  1  high while in RUN.
REQ-013 oC  output  LANES  per-lane product bitstream; valid only while busy.
REQ-014 done  output  1  one-cycle pulse when a run completes without abort.
REQ-015 oCnt  output  LANES*(DATAWD+1)  per-lane count of ones over the last completed run; lane k occupies bits [k*(DATAWD+1) +: DATAWD+1].

Function
REQ-016 FSM states: IDLE, RUN, DONE.
REQ-017 IDLE with start=1: latch iA, iB and mode into operand buffers; clear the cycle counter and all lane accumulators; next state RUN.
REQ-018 In RUN: a_k = (A_buf_k > sobolSeqA) and b_k = (B_buf_k > sobolSeqB), unsigned, both strict.
REQ-019 In RUN: oC[k] = a_k AND b_k when mode_buf=0, and oC[k] = XNOR(a_k, b_k) when mode_buf=1; combinational from buffers and sequences.
REQ-020 Outside RUN: oC = 0.
REQ-021 Each RUN cycle: increment the cycle counter, and add oC[k] to accumulator k (width DATAWD+1).
REQ-022 On the RUN cycle where the cycle counter equals 2^DATAWD-1: load oCnt[k] with accumulator k + oC[k]; next state DONE.
REQ-023 Run length is exactly 2^DATAWD RUN cycles; the first RUN cycle is the cycle after start is sampled.
REQ-024 DONE: done=1 for exactly that cycle; next state IDLE unconditionally.
REQ-025 start is ignored in RUN and DONE; no queueing.
REQ-026 abort=1 in RUN or DONE: next state IDLE; done not asserted; oCnt keeps its previous value.
REQ-027 abort=1 in IDLE: no effect; if start is also 1, abort has priority and start is ignored.
REQ-028 oCnt holds its value from the end of a run until the end of the next completed run.
REQ-029 Operand inputs change during RUN: no effect on the current run.
REQ-030 Bipolar count range is 0..2^DATAWD; no saturation or wrap at 2^DATAWD.

Reset
REQ-031 On rst_n low, asynchronously: state=IDLE; operand buffers, mode buffer, cycle counter, accumulators and oCnt = 0; busy=0; done=0; oC=0.
REQ-032 Reset asserted mid-run discards the run; no done pulse is produced.

Structure
REQ-033 Shared package sc_mul_pkg SHALL hold the FSM state enum and the mode encoding constants (MODE_UNI=0, MODE_BI=1).
REQ-034 Per-lane logic (comparators, AND/XNOR, accumulator) SHALL be one sub-module sc_mul_lane, instantiated LANES times by generate.
REQ-035 Cycle counter and FSM SHALL reside in the top module, shared by all lanes.

Verification
REQ-036 Verification conditions, all scenarios: DATAWD=8, LANES=4, sobolSeqA=sobolSeqB=cycle index 0..255.
REQ-037 Unipolar, lane0 A=128/B=64, lane1 A=255/B=255, lane2 A=0/B=200 -> oCnt lanes = 64, 255, 0; done is a single pulse 256 cycles after the first RUN cycle.
REQ-038 Bipolar, lane0 A=128/B=64, lane1 A=0/B=0 -> oCnt = 192 and 256; no overflow.
REQ-039 abort at RUN cycle 100 -> IDLE next cycle, no done, oCnt unchanged from the prior run, busy drops.
REQ-040 start held high through RUN plus iA toggled mid-run -> exactly one run, result from latched operands, new run begins only after DONE->IDLE.
REQ-041 rst_n pulsed low at RUN cycle 50 -> all outputs 0 immediately; a subsequent start produces a correct full run.
